mem_dbus_ctrl: RTL

Data-bus access controller in the MEM stage. It turns a load/store request from the MEM stage into a transaction on the SRAM-like data bus and stalls the pipeline while the access is outstanding. It registers the read data and feeds the write-back stage through `dm` and `mem_operation_ok`. On a pipeline flush it cancels or drains the in-flight access.

---
 rtl/mem_dbus_ctrl_pkg.sv | 22 ++
 rtl/mem_dbus_ctrl_size_enc.sv | 20 ++
 rtl/mem_dbus_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mem_dbus_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-bus controller: state codes,
// bus size codes and the byte-lane / word bus widths.
package mem_dbus_ctrl_pkg;

    localparam int BSEL_BUS = 4;
    localparam int WORD_BUS = 32;

    typedef logic [2:0]          dbus_state_t;
    typedef logic [BSEL_BUS-1:0] bsel_t;
    typedef logic [1:0]          dbus_size_t;

    localparam dbus_state_t DBUS_IDLE   = 3'd0;
    localparam dbus_state_t DBUS_REQ    = 3'd1;
    localparam dbus_state_t DBUS_WAIT   = 3'd2;
    localparam dbus_state_t DBUS_DONE   = 3'd3;
    localparam dbus_state_t DBUS_CANCEL = 3'd4;

    localparam dbus_size_t SIZE_BYTE = 2'd0;
    localparam dbus_size_t SIZE_HALF = 2'd1;
    localparam dbus_size_t SIZE_WORD = 2'd2;

endpackage

// File: rtl/mem_dbus_ctrl_size_enc.sv
// Byte-lane select to bus transfer size. Any pattern that is neither a full
// word nor an aligned half falls through to a byte access.
module mem_dbus_ctrl_size_enc
    import mem_dbus_ctrl_pkg::*;
(
    input  logic [3:0] bsel,
    output logic [1:0] size
);

    // Decode the lane pattern into the bus size code
    always_comb begin
        size = SIZE_BYTE;
        case (bsel)
            4'b1111:          size = SIZE_WORD;
            4'b1100, 4'b0011: size = SIZE_HALF;
            default:          size = SIZE_BYTE;
        endcase
    end

endmodule

// File: rtl/mem_dbus_ctrl.sv
// MEM-stage data-bus access controller. Converts one load/store into a single
// SRAM-like bus transaction, stalls the pipeline while it is outstanding,
// registers read data into dm and cancels/drains the access on a flush.
module mem_dbus_ctrl
    import mem_dbus_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst,
    input  logic              mem_req_i,
    input  logic              mem_wr_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [3:0]        mem_bsel_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic              flush_i,
    input  logic              pipe_hold_i,
    output logic              data_sram_req,
    output logic              data_sram_wr,
    output logic [1:0]        data_sram_size,
    output logic [ADDR_W-1:0] data_sram_addr,
    output logic [3:0]        data_sram_wstrb,
    output logic [DATA_W-1:0] data_sram_wdata,
    input  logic              data_sram_addr_ok,
    input  logic              data_sram_data_ok,
    input  logic [DATA_W-1:0] data_sram_rdata,
    output logic [DATA_W-1:0] dm,
    output logic              mem_operation_ok,
    output logic              stall_req_o
);

    dbus_state_t       state;
    dbus_state_t       state_nxt;
    logic              cancel_pend;
    logic              accept;
    logic              req_active;

    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [3:0]        req_bsel;
    logic [DATA_W-1:0] req_wdata;
    logic [1:0]        req_size;

    assign accept     = (state == DBUS_IDLE) && mem_req_i && !flush_i;
    assign req_active = (state == DBUS_REQ);

    mem_dbus_ctrl_size_enc u_size_enc (
        .bsel (req_bsel),
        .size (req_size)
    );

    // Next-state decision for the single outstanding bus transaction
    always_comb begin
        state_nxt = state;
        case (state)
            DBUS_IDLE: begin
                if (accept)
                    state_nxt = DBUS_REQ;
            end
            DBUS_REQ: begin
                // The request is never withdrawn; a flush only redirects
                // where the addr_ok handshake lands.
                if (data_sram_addr_ok)
                    state_nxt = (flush_i || cancel_pend) ? DBUS_CANCEL : DBUS_WAIT;
            end
            DBUS_WAIT: begin
                if (data_sram_data_ok)
                    state_nxt = flush_i ? DBUS_IDLE : DBUS_DONE;
                else if (flush_i)
                    state_nxt = DBUS_CANCEL;
            end
            DBUS_DONE: begin
                if (flush_i || !pipe_hold_i)
                    state_nxt = DBUS_IDLE;
            end
            DBUS_CANCEL: begin
                if (data_sram_data_ok)
                    state_nxt = DBUS_IDLE;
            end
            default: state_nxt = DBUS_IDLE;
        endcase
    end

    // FSM state and the pending-cancel flag for a flush seen before addr_ok
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            state       <= DBUS_IDLE;
            cancel_pend <= 1'b0;
        end else begin
            state <= state_nxt;
            if (req_active && !data_sram_addr_ok && flush_i)
                cancel_pend <= 1'b1;
            else if (!req_active)
                cancel_pend <= 1'b0;
            else if (data_sram_addr_ok)
                cancel_pend <= 1'b0;
        end
    end

    // Request fields are captured once on acceptance and held until addr_ok
    always_ff @(posedge cpu_clk_50M) begin
        if (accept) begin
            req_wr    <= mem_wr_i;
            req_addr  <= mem_addr_i;
            req_bsel  <= mem_bsel_i;
            req_wdata <= mem_wdata_i;
        end
    end

    // Read data register: only a load completing without a flush updates it
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst)
            dm <= '0;
        else if ((state == DBUS_WAIT) && data_sram_data_ok && !flush_i && !req_wr)
            dm <= data_sram_rdata;
    end

    // Bus outputs are driven only while requesting, so reset forces them to 0
    always_comb begin
        data_sram_req   = req_active;
        data_sram_wr    = req_active && req_wr;
        data_sram_size  = req_active ? req_size : SIZE_BYTE;
        data_sram_addr  = req_active ? req_addr : '0;
        data_sram_wstrb = (req_active && req_wr) ? req_bsel : 4'b0000;
        data_sram_wdata = req_active ? req_wdata : '0;
    end

    // Stall while a transaction is live, including the cycle it is accepted
    always_comb begin
        stall_req_o = accept || (state == DBUS_REQ) || (state == DBUS_WAIT)
                      || (state == DBUS_CANCEL);
        mem_operation_ok = !stall_req_o;
    end

endmodule
